// File: rtl/inst_memory_if.sv
// Interface bundling the fetch read port and the program-loader byte stream
// of inst_memory. The memory is the slave; the core/loader side is the master.
//
// Byte-stream handshake: a byte transfers on a rising clock edge where both
// load_byte_valid and load_byte_ready are 1. The producer must hold
// load_byte stable while valid is high and not yet accepted; ready does not
// depend on valid.
interface inst_memory_if #(
    parameter int DEPTH_WORDS = 1024
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]  memory_inst_address;
    logic [31:0]  memory_inst_data;
    logic         inst_fault;
    logic         load_start;
    logic [IDX_W:0] load_length;
    logic [7:0]   load_byte;
    logic         load_byte_valid;
    logic         load_byte_ready;
    logic         load_busy;
    logic         load_done;
    logic [1:0]   load_state;   // loader FSM state, for observation only

    modport master (
        output memory_inst_address, load_start, load_length,
               load_byte, load_byte_valid,
        input  memory_inst_data, inst_fault, load_byte_ready,
               load_busy, load_done, load_state
    );

    modport slave (
        input  memory_inst_address, load_start, load_length,
               load_byte, load_byte_valid,
        output memory_inst_data, inst_fault, load_byte_ready,
               load_busy, load_done, load_state
    );
endinterface

// File: rtl/inst_memory.sv
// inst_memory: instruction memory with a combinational fetch port and a
// byte-stream program loader that assembles little-endian words.
// While the loader is busy the fetch port returns NOP (32'h00000013).
// Optional feature macro: INST_MEM_BOUNDS_CHECK_EN -- when defined,
// misaligned or out-of-range fetch addresses return NOP and raise inst_fault.
// Loader state encoding on load_state: 0=IDLE, 1=LOAD, 2=DONE.
module inst_memory #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic clock,
    input  logic reset,
    inst_memory_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           ready_q;
    logic           busy_q;
    logic           done_q;
    logic [1:0]     byte_cnt;
    logic [IDX_W:0] word_cnt;
    logic [IDX_W:0] len_q;
    logic [23:0]    asm_q;      // lanes 0..2; lane 3 comes straight from load_byte

    logic [31:0] mem [DEPTH_WORDS];

    logic           hs;
    logic           wr_en;
    logic [31:0]    wr_data;
    logic [IDX_W-1:0] rd_idx;

    assign hs      = bus.load_byte_valid && ready_q;
    assign wr_en   = (state == LOAD) && hs && (byte_cnt == 2'd3) && !reset;
    assign wr_data = {bus.load_byte, asm_q};
    assign rd_idx  = bus.memory_inst_address[IDX_W+1:2];

    assign bus.load_byte_ready = ready_q;
    assign bus.load_busy       = busy_q;
    assign bus.load_done       = done_q;
    assign bus.load_state      = state;

    // Loader FSM with registered handshake/status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            len_q    <= '0;
            asm_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load_start && (bus.load_length != '0)) begin
                        len_q    <= (bus.load_length > DEPTH_CNT) ? DEPTH_CNT : bus.load_length;
                        byte_cnt <= 2'd0;
                        word_cnt <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        case (byte_cnt)
                            2'd0:    asm_q[7:0]   <= bus.load_byte;
                            2'd1:    asm_q[15:8]  <= bus.load_byte;
                            2'd2:    asm_q[23:16] <= bus.load_byte;
                            default: asm_q        <= asm_q;
                        endcase
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= 2'd0;
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt == len_q - 1'b1) begin
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state   <= DONE;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Array write port; contents are never reset so a reset keeps loaded words.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[word_cnt[IDX_W-1:0]] <= wr_data;
        end
    end

`ifdef INST_MEM_BOUNDS_CHECK_EN
    logic addr_bad;
    assign addr_bad = (bus.memory_inst_address[1:0] != 2'b00) ||
                      (bus.memory_inst_address[31:IDX_W+2] != '0);

    // Fetch read: busy NOP has priority over the bounds fault.
    always_comb begin
        bus.memory_inst_data = mem[rd_idx];
        bus.inst_fault       = 1'b0;
        if (busy_q) begin
            bus.memory_inst_data = NOP;
        end else if (addr_bad) begin
            bus.memory_inst_data = NOP;
            bus.inst_fault       = 1'b1;
        end
    end
`else
    // Byte-offset and upper address bits are deliberately ignored (index wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.memory_inst_address[31:IDX_W+2],
                                bus.memory_inst_address[1:0]};

    // Fetch read: NOP while the loader owns the array.
    always_comb begin
        bus.memory_inst_data = busy_q ? NOP : mem[rd_idx];
        bus.inst_fault       = 1'b0;
    end
`endif
endmodule

// File: tb/tb_inst_memory.sv
// Directed testbench for inst_memory: loader FSM timing, little-endian word
// assembly, NOP during load, zero/oversize lengths, reset mid-load and
// address decoding with or without INST_MEM_BOUNDS_CHECK_EN.
module tb_inst_memory;
    localparam int DEPTH = 1024;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   done_seen;

    inst_memory_if #(.DEPTH_WORDS(DEPTH)) bus ();

    inst_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count load_done pulses sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.load_done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: each is entered 1 time unit after a rising edge and returns likewise.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input int len);
        bus.load_start  = 1'b1;
        bus.load_length = (IDX_W + 1)'(len);
        tick();
        bus.load_start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            bus.load_byte_valid = 1'b0;
            bus.load_byte       = 8'h55;   // garbage that must not be captured
            tick();
        end
        bus.load_byte_valid = 1'b1;
        bus.load_byte       = b;
        tick();
        bus.load_byte_valid = 1'b0;
    endtask

    task automatic read_at(input logic [31:0] addr);
        bus.memory_inst_address = addr;
        #1;
    endtask

    logic [7:0] prog2 [8];
    int         done_before;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        done_seen = 0;
        prog2 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        reset                   = 1'b1;
        bus.memory_inst_address = 32'h0;
        bus.load_start          = 1'b0;
        bus.load_length         = '0;
        bus.load_byte           = 8'h00;
        bus.load_byte_valid     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_state", 32'(bus.load_state), 32'd0);
        check("rst_ready", 32'(bus.load_byte_ready), 32'd0);
        check("rst_busy", 32'(bus.load_busy), 32'd0);
        check("rst_done", 32'(bus.load_done), 32'd0);

        // Two-word load with valid held high
        done_before = done_seen;
        start_load(2);
        check("ld2_busy", 32'(bus.load_busy), 32'd1);
        check("ld2_ready", 32'(bus.load_byte_ready), 32'd1);
        check("ld2_state", 32'(bus.load_state), 32'd1);
        read_at(32'h0);
        check("ld2_nop_rd", bus.memory_inst_data, NOP);
        check("ld2_nop_flt", 32'(bus.inst_fault), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus.load_byte_valid = 1'b1;
            bus.load_byte       = prog2[i];
            tick();
        end
        bus.load_byte_valid = 1'b0;
        check("ld2_done", 32'(bus.load_done), 32'd1);
        check("ld2_done_st", 32'(bus.load_state), 32'd2);
        check("ld2_done_busy", 32'(bus.load_busy), 32'd0);
        check("ld2_done_rdy", 32'(bus.load_byte_ready), 32'd0);
        tick();
        check("ld2_idle", 32'(bus.load_state), 32'd0);
        check("ld2_done_low", 32'(bus.load_done), 32'd0);
        check("ld2_pulses", 32'(done_seen - done_before), 32'd1);
        read_at(32'h0);
        check("ld2_w0", bus.memory_inst_data, 32'h00000013);
        read_at(32'h4);
        check("ld2_w1", bus.memory_inst_data, 32'h00100093);

        // Address decode at the array boundary and misaligned
`ifdef INST_MEM_BOUNDS_CHECK_EN
        read_at(32'h2);
        check("bc_mis_data", bus.memory_inst_data, NOP);
        check("bc_mis_flt", 32'(bus.inst_fault), 32'd1);
        read_at(32'(4 * DEPTH + 4));
        check("bc_oor_data", bus.memory_inst_data, NOP);
        check("bc_oor_flt", 32'(bus.inst_fault), 32'd1);
`else
        read_at(32'(4 * DEPTH));
        check("wrap_data", bus.memory_inst_data, 32'h00000013);
        check("wrap_flt", 32'(bus.inst_fault), 32'd0);
        read_at(32'(4 * DEPTH + 6));
        check("wrap_mis_data", bus.memory_inst_data, 32'h00100093);
        check("wrap_mis_flt", 32'(bus.inst_fault), 32'd0);
`endif

        // One word with valid toggling; only accepted bytes are assembled
        done_before = done_seen;
        start_load(1);
        send_byte(8'hef, 1'b1);
        send_byte(8'hbe, 1'b1);
        send_byte(8'had, 1'b1);
        check("tog_still_busy", 32'(bus.load_busy), 32'd1);
        send_byte(8'hde, 1'b1);
        check("tog_done", 32'(bus.load_done), 32'd1);
        tick();
        check("tog_pulses", 32'(done_seen - done_before), 32'd1);
        read_at(32'h0);
        check("tog_w0", bus.memory_inst_data, 32'hdeadbeef);
        read_at(32'h4);
        check("tog_w1_kept", bus.memory_inst_data, 32'h00100093);

        // Zero length is ignored; bytes offered in IDLE are not consumed
        start_load(0);
        check("zero_state", 32'(bus.load_state), 32'd0);
        check("zero_busy", 32'(bus.load_busy), 32'd0);
        bus.load_byte_valid = 1'b1;
        bus.load_byte       = 8'h77;
        #1;
        check("zero_ready", 32'(bus.load_byte_ready), 32'd0);
        tick();
        bus.load_byte_valid = 1'b0;
        read_at(32'h0);
        check("zero_w0", bus.memory_inst_data, 32'hdeadbeef);

        // Reset after 5 bytes of a 2-word load
        start_load(2);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h88, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstld_state", 32'(bus.load_state), 32'd0);
        check("rstld_busy", 32'(bus.load_busy), 32'd0);
        check("rstld_ready", 32'(bus.load_byte_ready), 32'd0);
        read_at(32'h0);
        check("rstld_w0", bus.memory_inst_data, 32'h11223344);
        read_at(32'h4);
        check("rstld_w1", bus.memory_inst_data, 32'h00100093);

        // Oversize length clamps to DEPTH words; word i = 0x5AA5_0000 | i
        done_before = done_seen;
        start_load(DEPTH + 5);
        bus.load_byte_valid = 1'b1;
        for (int w = 0; w < DEPTH; w++) begin
            bus.load_byte = 8'(w);
            tick();
            bus.load_byte = 8'(w >> 8);
            tick();
            bus.load_byte = 8'ha5;
            tick();
            bus.load_byte = 8'h5a;
            tick();
        end
        check("big_done", 32'(bus.load_done), 32'd1);
        check("big_ready", 32'(bus.load_byte_ready), 32'd0);
        tick();
        bus.load_byte_valid = 1'b0;
        check("big_idle", 32'(bus.load_state), 32'd0);
        check("big_pulses", 32'(done_seen - done_before), 32'd1);
        read_at(32'h0);
        check("big_w0", bus.memory_inst_data, 32'h5aa50000);
        read_at(32'(4 * 513));
        check("big_w513", bus.memory_inst_data, 32'h5aa50201);
        read_at(32'(4 * (DEPTH - 1)));
        check("big_wlast", bus.memory_inst_data, 32'h5aa503ff);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_memory.md
# inst_memory

Instruction-memory responder for the single-issue core: serves the fetch stage's `memory_inst_address` with same-cycle `memory_inst_data`. It also contains a byte-stream program loader FSM that fills the array with little-endian words before or between runs. It holds the core on a NOP stream while loading.

## Interface
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two, ≥ 4.
- `IDX_W`, $clog2(DEPTH_WORDS): word-index width (derived; not overridden).
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`.
- `memory_inst_address`  in  32  byte address from fetch stage.
- `memory_inst_data`  out  32  instruction word (combinational read).
- `inst_fault`  out  1  address misaligned/out of range (only with bounds check; else 0).
- `load_start`  in  1  one-cycle request to begin loading.
- `load_length`  in  IDX_W+1  number of words to load, sampled with `load_start`.
- `load_byte`  in  8  program byte.
- `load_byte_valid`  in  1  `load_byte` valid.
- `load_byte_ready`  out  1  loader accepts a byte this cycle.
- `load_busy`  out  1  loader active; core must treat fetched data as NOP.
- `load_done`  out  1  one-cycle pulse after the final word is written.

## Operation
- Array: `DEPTH_WORDS` x 32 b, no reset of contents. Read index = `memory_inst_address[IDX_W+1:2]`.
- Read port: `memory_inst_data` = array[index] combinationally when `load_busy`=0. When `load_busy`=1 it is 32'h00000013 (NOP).
- FSM states: IDLE, LOAD, DONE.
  - IDLE: `load_byte_ready`=0. On `load_start`=1 and `load_length`≠0: latch length, clamped to `DEPTH_WORDS`; clear `byte_cnt` (2 b) and `word_cnt` (IDX_W+1 b); go to LOAD. A `load_length` of 0 is ignored, and the FSM stays in IDLE.
  - LOAD: `load_byte_ready`=1, `load_busy`=1. Each handshake (`valid`&&`ready`) shifts the byte into assembly register lane `byte_cnt`, where lane 0 = bits[7:0]. On the handshake with `byte_cnt`==3, write the assembled word (this byte in bits[31:24]) to array[`word_cnt`], increment `word_cnt`, and wrap `byte_cnt` to 0. If that word was number length−1, go to DONE.
  - DONE: `load_done`=1, `load_busy`=0, `load_byte_ready`=0; next cycle go to IDLE.
- `load_start` outside IDLE is ignored. Bytes offered outside LOAD are not consumed.
- A partial word (byte_cnt≠0) is never written. Loading resumes only on more bytes; there is no timeout.

## Timing
- Reset values: FSM=IDLE, `load_byte_ready`=0, `load_busy`=0, `load_done`=0, counters=0. `memory_inst_data` and `inst_fault` follow the combinational rules above.
- `reset` asserted mid-LOAD aborts the load; already-written words are kept. Busy drops the cycle after the reset edge.
- Read latency 0 cycles; a word written at edge N is readable from cycle N onward.
- `load_start` at edge N → `load_busy`=1 and ready=1 during cycle N+1.
- Final byte handshake at edge M → DONE during cycle M+1 (`load_done` pulse) → IDLE at M+2.
- Minimum load time for L words: 4L handshake cycles + 2.

## Configuration
- `INST_MEM_BOUNDS_CHECK_EN` defined: if `memory_inst_address[1:0]`≠0 or `memory_inst_address[31:IDX_W+2]`≠0, then `memory_inst_data`=32'h00000013 and `inst_fault`=1 (combinational; `load_busy` NOP takes priority, and fault=0 while busy).
- Not defined: upper and low address bits are ignored, the index wraps modulo `DEPTH_WORDS`, and `inst_fault` is tied 0.

## Test plan
- Load 2 words from bytes 13,00,00,00,93,00,10,00 (hex) with valid always high → array[0]=0x00000013, array[1]=0x00100093. `load_done` pulses exactly once, 1 cycle after the 8th handshake.
- Read during LOAD at address 0x0 → `memory_inst_data`=0x00000013 while `load_busy`=1. After DONE, address 0x4 reads 0x00100093.
- Valid toggled every other cycle with `load_length`=1 → only handshaked bytes are assembled, and the word is written after the 4th accepted byte.
- `load_length`=0 → FSM stays IDLE. `load_length`=DEPTH_WORDS+5 → exactly DEPTH_WORDS words are written, then DONE.
- Reset after 5 bytes of a 2-word load → word 0 retained, word 1 unchanged, FSM IDLE, `load_busy`=0.
- With `INST_MEM_BOUNDS_CHECK_EN`: address 0x2 → NOP and `inst_fault`=1; address 4·DEPTH_WORDS → NOP and fault=1. Without it: address 4·DEPTH_WORDS reads array[0] and fault=0.
